ram_burst_ctrl: RTL and testbench
=================================

Name: ram_burst_ctrl

Overview:
Burst sequencer that sits directly upstream of the 16x4 single-port RAM (ports CLK/A/D/EN/WR/Q, 1-cycle registered read).
- Accepts burst requests (start address, length, direction) on a valid/ready channel.
- Streams write beats into the RAM, or issues reads and returns data on a back-pressurable output stream.
- Hides RAM read latency and address sequencing from the client.

Parameters:
AW, 4, RAM address width; addresses wrap modulo 2^AW.
DW, 4, data width; must match the RAM data width.
LENW, 4, burst-length field width; burst beats = REQ_LEN+1 (1..2^LENW).

Ports:
CLK  in  1  clock; all state updates on posedge.
RST_N  in  1  asynchronous active-low reset.
REQ_VALID  in  1  burst request valid.
REQ_READY  out  1  controller can accept a request (IDLE only).
REQ_WR  in  1  1 = write burst, 0 = read burst.
REQ_ADDR  in  AW  burst start address.
REQ_LEN  in  LENW  beats minus one.
WD_VALID  in  1  write-data beat valid.
WD_READY  out  1  write beat accepted this cycle.
WD_DATA  in  DW  write-data beat.
RD_VALID  out  1  read-data beat valid.
RD_READY  in  1  consumer accepts read beat.
RD_DATA  out  DW  read-data beat.
RD_LAST  out  1  final beat of the read burst.
BUSY  out  1  state != IDLE.
RAM_EN  out  1  to RAM EN.
RAM_WR  out  1  to RAM WR.
RAM_A  out  AW  to RAM A.
RAM_D  out  DW  to RAM D.
RAM_Q  in  DW  from RAM Q; valid the cycle after a read issue.

Behaviour:
- Reset (RST_N=0, async): state=IDLE; addr, count, in-flight flag and buffer cleared.
- Reset values: REQ_READY=0 while in reset, then 1 once in IDLE. WD_READY, RD_VALID, RD_LAST, BUSY, RAM_EN, RAM_WR = 0. RAM_A, RAM_D, RD_DATA = 0.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID&REQ_READY: latch addr=REQ_ADDR, count=REQ_LEN, tag=REQ_WR.
  - Go to WRITE if REQ_WR=1, else READ.
- WRITE:
  - WD_READY=1.
  - RAM_EN=WD_VALID, RAM_WR=1, RAM_A=addr, RAM_D=WD_DATA (combinational pass-through).
  - Per accepted beat: addr<=addr+1 (wraps F->0), count<=count-1.
  - Beat accepted with count==0 -> IDLE.
  - WD_VALID gaps stall without issuing.
- READ, issue rule:
  - Issue when (buffer occupancy + inflight) < 2.
  - Issue drives RAM_EN=1, RAM_WR=0, RAM_A=addr.
  - On issue: inflight<=1, addr++, count--, and last-tag<=(count==0).
  - Issue with count==0 -> DRAIN.
- READ/DRAIN, capture rule:
  - In the cycle after an issue (inflight=1), push {RAM_Q, last-tag} into a 2-entry output buffer; inflight clears unless re-issued.
  - RAM_Q is ignored when inflight=0; RAM Q holds stale data then.
- Output side:
  - RD_VALID = buffer non-empty; RD_DATA/RD_LAST come from the buffer head.
  - Pop on RD_VALID&RD_READY.
  - Simultaneous push and pop is legal; occupancy is unchanged.
- DRAIN: no new issues. -> IDLE when buffer empty, inflight=0 and no push pending.
- Latency:
  - Write: data reaches the RAM on the same cycle it is accepted.
  - Read: first RD_VALID 2 cycles after the request handshake.
  - Sustained read throughput is 1 beat/cycle while RD_READY=1.
- Buffer never overflows: guaranteed by the issue rule. Back-pressure stalls issuing, never drops data.
- RAM applies its own MASK to stored and read data; the controller is data-transparent.
- Mid-burst reset: burst is abandoned, buffer flushed; no RAM_EN after reset assertion; no RD_LAST is produced.
- REQ_VALID outside IDLE is ignored (REQ_READY=0).
- Length 2^LENW with AW=4 covers the whole array exactly once.

Decomposition:
- Package ram_burst_pkg:
  - state enum (IDLE, WRITE, READ, DRAIN);
  - default widths AW/DW/LENW;
  - output-buffer depth constant OBUF_DEPTH=2.
- One sub-module: ram_burst_obuf.
  - 2-entry synchronous FIFO of {data, last} with push/pop/full/empty.
  - Same CLK/RST_N.
- Bench instantiates ram_burst_ctrl wired to ram_4x4, with ram_4x4 MASK overridden to 15 for transparent data.

Test Plan:
- Write burst addr=0xE, len=3, data 3,4,5,6 with WD_VALID always 1 -> RAM writes at A=E,F,0,1 on 4 consecutive cycles; BUSY falls after the 4th beat.
- Read burst addr=0xE, len=3, RD_READY=1 -> RD_VALID 2 cycles after the handshake; data 3,4,5,6 on consecutive cycles; RD_LAST only on 6.
- Same read with RD_READY low for cycles 3-6 of the burst -> at most 2 buffered; no RAM_EN issued while occupancy+inflight=2; data order 3,4,5,6 preserved with no drops.
- Full-array write len=15 with data = addr, then read len=15 from 0x5 -> outputs 5..F,0..4; RD_LAST on 4.
- Write burst with WD_VALID toggling 1,0,1,0 -> RAM_EN mirrors WD_VALID; addr advances only on accepted beats.
- RST_N pulsed low mid read burst (after 2 beats) -> all outputs 0 immediately; REQ_READY=1 after release; a new read request completes normally.

Source files
------------

// File: rtl/ram_burst_pkg.sv
// Shared types and default widths for the RAM burst sequencer.
package ram_burst_pkg;
  localparam int AW_DEF     = 4;
  localparam int DW_DEF     = 4;
  localparam int LENW_DEF   = 4;
  localparam int OBUF_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;
endpackage

// File: rtl/ram_4x4.sv
// 16x4 single-port RAM with a registered read port and a data mask on store and load.
module ram_4x4 #(
  parameter logic [3:0] MASK = 4'h7
) (
  input  logic       CLK,
  input  logic [3:0] A,
  input  logic [3:0] D,
  input  logic       EN,
  input  logic       WR,
  output logic [3:0] Q
);
  logic [3:0] mem_q [16];

  // Q deliberately holds its last value when no read is issued.
  always_ff @(posedge CLK) begin
    if (EN) begin
      if (WR) mem_q[A] <= D & MASK;
      else    Q        <= mem_q[A] & MASK;
    end
  end
endmodule

// File: rtl/ram_burst_obuf.sv
// Small synchronous FIFO holding {data, last} read beats between the RAM and the client.
module ram_burst_obuf
  import ram_burst_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int OW = $clog2(OBUF_DEPTH + 1);

  logic [DW-1:0]         data_q [OBUF_DEPTH];
  logic [DW-1:0]         data_d [OBUF_DEPTH];
  logic [OBUF_DEPTH-1:0] last_q, last_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         occ_q, occ_d;

  assign head_data = data_q[rd_ptr_q];
  assign head_last = last_q[rd_ptr_q];
  assign full      = (occ_q == OW'(OBUF_DEPTH));
  assign empty     = (occ_q == '0);

  always_comb begin
    data_d   = data_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      data_d[wr_ptr_q] = push_data;
      last_d[wr_ptr_q] = push_last;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q   <= '{default: '0};
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      data_q   <= data_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end
endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of a single-port RAM: streams write beats in, and
// issues reads whose registered results are buffered onto a back-pressurable stream.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic            REQ_WR,
  input  logic [AW-1:0]   REQ_ADDR,
  input  logic [LENW-1:0] REQ_LEN,
  input  logic            WD_VALID,
  output logic            WD_READY,
  input  logic [DW-1:0]   WD_DATA,
  output logic            RD_VALID,
  input  logic            RD_READY,
  output logic [DW-1:0]   RD_DATA,
  output logic            RD_LAST,
  output logic            BUSY,
  output logic            RAM_EN,
  output logic            RAM_WR,
  output logic [AW-1:0]   RAM_A,
  output logic [DW-1:0]   RAM_D,
  input  logic [DW-1:0]   RAM_Q,
  output state_e          DBG_STATE
);
  // All channels are valid/ready: a transfer happens on a rising CLK edge where
  // both are high; valid never waits on ready, and payload is held while valid && !ready.
  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LENW-1:0] count_q, count_d;
  logic            inflight_q, inflight_d;
  logic            infl_last_q, infl_last_d;

  logic            ob_full, ob_empty, ob_pop, room;
  logic [DW-1:0]   ob_head_data;
  logic            ob_head_last;

  ram_burst_obuf #(.DW(DW)) u_obuf (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .push     (inflight_q),
    .push_data(RAM_Q),
    .push_last(infl_last_q),
    .pop      (ob_pop),
    .head_data(ob_head_data),
    .head_last(ob_head_last),
    .full     (ob_full),
    .empty    (ob_empty)
  );

  assign ob_pop    = !ob_empty && RD_READY;
  assign RD_VALID  = !ob_empty;
  assign RD_DATA   = ob_empty ? '0 : ob_head_data;
  assign RD_LAST   = !ob_empty && ob_head_last;
  assign BUSY      = (state_q != S_IDLE);
  assign DBG_STATE = state_q;

  // Occupancy after this cycle's pop plus the beat in flight must stay below two;
  // counting the pop keeps one beat per cycle flowing while the client is ready.
  assign room = inflight_q ? (ob_empty || (ob_pop && !ob_full)) : (!ob_full || ob_pop);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    inflight_d  = 1'b0;
    infl_last_d = infl_last_q;
    REQ_READY   = 1'b0;
    WD_READY    = 1'b0;
    RAM_EN      = 1'b0;
    RAM_WR      = 1'b0;
    RAM_A       = '0;
    RAM_D       = '0;
    case (state_q)
      S_IDLE: begin
        REQ_READY = RST_N;
        if (REQ_VALID) begin
          addr_d  = REQ_ADDR;
          count_d = REQ_LEN;
          state_d = REQ_WR ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        WD_READY = 1'b1;
        RAM_EN   = WD_VALID;
        RAM_WR   = 1'b1;
        RAM_A    = addr_q;
        RAM_D    = WD_DATA;
        if (WD_VALID) begin
          addr_d  = addr_q + AW'(1);
          count_d = count_q - LENW'(1);
          if (count_q == '0) state_d = S_IDLE;
        end
      end
      S_READ: begin
        RAM_A = addr_q;
        if (room) begin
          RAM_EN      = 1'b1;
          inflight_d  = 1'b1;
          infl_last_d = (count_q == '0);
          addr_d      = addr_q + AW'(1);
          count_d     = count_q - LENW'(1);
          if (count_q == '0) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ob_empty && !inflight_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
    end
  end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl driving a real ram_4x4 with an unmasked data path.
module tb_ram_burst_ctrl;
  import ram_burst_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid, req_ready, req_wr;
  logic [3:0] req_addr, req_len;
  logic       wd_valid, wd_ready;
  logic [3:0] wd_data;
  logic       rd_valid, rd_ready, rd_last;
  logic [3:0] rd_data;
  logic       busy, ram_en, ram_wr;
  logic [3:0] ram_a, ram_d, ram_q;
  state_e     dbg_state;

  ram_burst_ctrl dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WR(req_wr),
    .REQ_ADDR(req_addr), .REQ_LEN(req_len),
    .WD_VALID(wd_valid), .WD_READY(wd_ready), .WD_DATA(wd_data),
    .RD_VALID(rd_valid), .RD_READY(rd_ready), .RD_DATA(rd_data), .RD_LAST(rd_last),
    .BUSY(busy), .RAM_EN(ram_en), .RAM_WR(ram_wr), .RAM_A(ram_a), .RAM_D(ram_d),
    .RAM_Q(ram_q), .DBG_STATE(dbg_state)
  );

  ram_4x4 #(.MASK(4'd15)) u_ram (
    .CLK(clk), .A(ram_a), .D(ram_d), .EN(ram_en), .WR(ram_wr), .Q(ram_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rd_pops = 0;
  logic [4:0] rd_exp_q[$];
  logic [7:0] wr_exp_q[$];
  logic [3:0] model_mem[16];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard monitor: compare every read beat taken and every RAM write issued.
  always @(negedge clk) begin
    logic [4:0] re;
    logic [7:0] we;
    if (rd_valid && rd_ready) begin
      if (rd_exp_q.size() == 0) check("rd_unexpected_beat", 1, 0);
      else begin
        re = rd_exp_q.pop_front();
        check("rd_data", int'(rd_data), int'(re[4:1]));
        check("rd_last", int'(rd_last), int'(re[0]));
      end
      rd_pops++;
    end
    if (ram_en && ram_wr) begin
      if (wr_exp_q.size() == 0) check("wr_unexpected_beat", 1, 0);
      else begin
        we = wr_exp_q.pop_front();
        check("wr_addr", int'(ram_a), int'(we[7:4]));
        check("wr_data", int'(ram_d), int'(we[3:0]));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, int'(req_ready), 0);
    check({tag, "_wd_ready"}, int'(wd_ready), 0);
    check({tag, "_rd_valid"}, int'(rd_valid), 0);
    check({tag, "_rd_last"}, int'(rd_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ram_en"}, int'(ram_en), 0);
    check({tag, "_ram_wr"}, int'(ram_wr), 0);
    check({tag, "_ram_a"}, int'(ram_a), 0);
    check({tag, "_ram_d"}, int'(ram_d), 0);
    check({tag, "_rd_data"}, int'(rd_data), 0);
  endtask

  task automatic issue_req(input logic wr, input logic [3:0] addr, input logic [3:0] len);
    check("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_len   = len;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("req_ready_busy", int'(req_ready), 0);
    check("busy_after_req", int'(busy), 1);
  endtask

  task automatic write_burst(input logic [3:0] addr, input logic [3:0] len,
                             input logic [3:0] base, input bit toggle);
    int beats = 0;
    bit done = 0;
    logic v;
    logic [3:0] a;
    issue_req(1'b1, addr, len);
    for (int cyc = 0; cyc < 100; cyc++) begin
      v        = toggle ? (cyc % 2 == 0) : 1'b1;
      a        = addr + 4'(beats);
      wd_valid = v;
      wd_data  = base + 4'(beats);
      if (v) begin
        wr_exp_q.push_back({a, wd_data});
        model_mem[a] = wd_data;
      end
      @(negedge clk);
      check("ram_en_mirror", int'(ram_en), int'(v));
      check("wd_ready", int'(wd_ready), 1);
      @(posedge clk); #1;
      if (v) beats++;
      if (beats > int'(len)) begin
        done = 1;
        break;
      end
    end
    wd_valid = 1'b0;
    check("write_done", int'(done), 1);
    check("busy_after_write", int'(busy), 0);
    check("wr_queue_drained", wr_exp_q.size(), 0);
  endtask

  task automatic push_read_exp(input logic [3:0] addr, input logic [3:0] len);
    logic [3:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 4'(i);
      rd_exp_q.push_back({model_mem[a], (i == int'(len))});
    end
  endtask

  task automatic read_burst(input logic [3:0] addr, input logic [3:0] len, input bit bp);
    int issued = 0;
    int popped = 0;
    bit done = 0;
    push_read_exp(addr, len);
    issue_req(1'b0, addr, len);
    for (int cyc = 0; cyc < 200; cyc++) begin
      rd_ready = !(bp && cyc >= 3 && cyc <= 6);
      @(negedge clk);
      if (cyc == 1) check("rd_latency_early", int'(rd_valid), 0);
      if (cyc == 2) check("rd_latency_first", int'(rd_valid), 1);
      if (ram_en && !ram_wr) issued++;
      if (rd_valid && rd_ready) popped++;
      check("outstanding_le2", int'((issued - popped) <= 2), 1);
      if (bp && cyc >= 3 && cyc <= 6) check("bp_no_issue", int'(ram_en), 0);
      if (!bp && cyc == 2 + int'(len)) check("rd_throughput", popped, int'(len) + 1);
      @(posedge clk); #1;
      if (rd_exp_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    rd_ready = 1'b1;
    check("read_done", int'(done), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("req_ready_after_reset", int'(req_ready), 1);
    check("busy_after_reset", int'(busy), 0);
    rd_ready = 1'b1;

    // Wrapping write then read of the same four words.
    write_burst(4'hE, 4'd3, 4'd3, 1'b0);
    read_burst(4'hE, 4'd3, 1'b0);
    read_burst(4'hE, 4'd3, 1'b1);

    // Whole array, read back starting mid-array.
    write_burst(4'h0, 4'd15, 4'd0, 1'b0);
    read_burst(4'h5, 4'd15, 1'b0);

    // Gapped write, then confirm what landed.
    write_burst(4'h8, 4'd3, 4'hA, 1'b1);
    read_burst(4'h8, 4'd3, 1'b0);

    // Reset in the middle of a read burst.
    rd_pops = 0;
    push_read_exp(4'h8, 4'd7);
    issue_req(1'b0, 4'h8, 4'd7);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (rd_pops >= 2) break;
    end
    check("midrst_two_beats_seen", rd_pops, 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    rd_exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_hold_ram_en", int'(ram_en), 0);
      check("midrst_hold_rd_valid", int'(rd_valid), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("req_ready_after_midrst", int'(req_ready), 1);
    check("busy_after_midrst", int'(busy), 0);
    read_burst(4'h0, 4'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
